fir_out_buffer: RTL



---
 rtl/fir_out_buffer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fir_out_buffer.sv
// Output stage for the FIR: captures each decimated sample, discards SKIP settling
// samples after fir_valid rises, and queues the rest in a FIFO. Define OUTBUF_STATS_EN for drop/high-water stats.
module fir_out_buffer #(
  parameter int WIDTH      = 14,
  parameter int DEPTH      = 16,
  parameter int SKIP       = 2,
  parameter int SIGNED_OUT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fir_clk_ds,
  input  logic [WIDTH-1:0]         fir_data,
  input  logic                     fir_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef OUTBUF_STATS_EN
  ,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   max_level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [7:0] SKIP_INIT = 8'(SKIP - 1);
  localparam logic       INV_MSB   = (SIGNED_OUT != 0);

  logic             ds_q;
  logic             cap;
  logic [1:0]       state_reg, state_next;
  logic [7:0]       skip_cnt_reg, skip_cnt_next;
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wdata;
  logic             push_req, push, pop, drop, full, empty;

  // fir_data settles one clk after the downsampled clock rises, hence the delayed strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_q <= 1'b0;
      cap  <= 1'b0;
    end else begin
      ds_q <= fir_clk_ds;
      cap  <= fir_clk_ds & ~ds_q;
    end
  end

  // The capture that wakes the FSM from IDLE is itself the first discarded sample.
  always_comb begin
    state_next    = state_reg;
    skip_cnt_next = skip_cnt_reg;
    push_req      = 1'b0;
    if (!fir_valid) begin
      state_next = IDLE;
    end else if (cap) begin
      case (state_reg)
        IDLE: begin
          if (SKIP == 0) begin
            push_req   = 1'b1;
            state_next = RUN;
          end else if (SKIP == 1) begin
            state_next = RUN;
          end else begin
            state_next    = PRIME;
            skip_cnt_next = SKIP_INIT;
          end
        end
        PRIME: begin
          if (skip_cnt_reg == 8'd1) state_next = RUN;
          else skip_cnt_next = skip_cnt_reg - 8'd1;
        end
        RUN:     push_req = 1'b1;
        default: state_next = IDLE;
      endcase
    end
  end

  assign wdata = {fir_data[WIDTH-1] ^ INV_MSB, fir_data[WIDTH-2:0]};
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop   = ~empty & out_ready;
  // A pop in the same cycle frees the slot the write lands in.
  assign push  = push_req & (~full | pop);
  assign drop  = push_req & full & ~pop;

  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign level     = wr_ptr_reg - rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      skip_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow     <= 1'b0;
`ifdef OUTBUF_STATS_EN
      drop_count   <= '0;
      max_level    <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      skip_cnt_reg <= skip_cnt_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (drop) overflow <= 1'b1;
`ifdef OUTBUF_STATS_EN
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (level > max_level) max_level <= level;
`endif
    end
  end

endmodule
